// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipeline hazard/forwarding controller.
package pipeline_pkg;

   // EX-stage operand mux selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // result_src encoding that marks a load in EX
   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   // Multi-cycle execute-unit sequencer states
   typedef enum logic [0:0] {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_e;

   // True when a result_src value denotes a load
   function automatic logic is_load(input logic [1:0] result_src);
      return result_src == RESULT_SRC_LOAD;
   endfunction

endpackage

// File: rtl/mc_sequencer.sv
// Multi-cycle EX occupancy sequencer: tracks how long a MUL/DIV holds EX.
// The first EX cycle is spent in IDLE (start seen), the rest in BUSY while a
// down-counter runs from MC_LATENCY-2 to 0; the zero cycle is the done cycle.
module mc_sequencer
   import pipeline_pkg::*;
#(
   parameter int unsigned MC_LATENCY = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic mstall,
   output logic busy,
   output logic done,
   output logic mcstall
);

   localparam int unsigned CntW = (MC_LATENCY > 2) ? $clog2(MC_LATENCY) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(MC_LATENCY - 2);

   mc_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // State and counter registers; reset abandons any op in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= MC_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: everything freezes while data memory is waiting
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!mstall) begin
         unique case (state_q)
            MC_IDLE: begin
               if (start) begin
                  state_d = MC_BUSY;
                  cnt_d   = CntLoad;
               end
            end
            MC_BUSY: begin
               if (cnt_q == '0) begin
                  state_d = MC_IDLE;
               end else begin
                  cnt_d = cnt_q - CntW'(1);
               end
            end
         endcase
      end
   end

   // Status outputs; start is ignored while BUSY
   always_comb begin
      busy    = (state_q == MC_BUSY);
      done    = busy && (cnt_q == '0);
      mcstall = ((state_q == MC_IDLE) && start) || (busy && !done);
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline. Drives per-stage
// stall/flush and the two EX forwarding muxes. Priority, highest first:
// memory wait, multi-cycle EX, redirect, load-use/RAW stall.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned MC_LATENCY = 4,
   parameter bit          FWD_EN     = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_e,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   input  logic              load_e,
   input  logic              pc_src_e,
   input  logic              mc_start_e,
   input  logic              dmem_req_m,
   input  logic              dmem_ready_m,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output logic              flush_w,
   output logic [1:0]        forward_ae,
   output logic [1:0]        forward_be,
   output logic              mc_busy,
   output logic              mc_done
);

   logic mstall;
   logic mcstall;
   logic seq_busy;
   logic seq_done;
   logic data_hazard;

   // Producer writes a nonzero rd that matches the consumer's source
   function automatic logic reg_hit(input logic              we,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] rs);
      return we && (rd != '0) && (rd == rs);
   endfunction

   // Forward select for one EX operand; MEM is the younger producer and wins
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
      if (reg_hit(reg_write_m, rd_m, rs)) begin
         return FWD_MEM;
      end else if (reg_hit(reg_write_w, rd_w, rs)) begin
         return FWD_WB;
      end
      return FWD_RF;
   endfunction

   assign mstall = dmem_req_m && !dmem_ready_m;

   mc_sequencer #(
      .MC_LATENCY(MC_LATENCY)
   ) u_mc_sequencer (
      .clk    (clk),
      .reset  (reset),
      .start  (mc_start_e),
      .mstall (mstall),
      .busy   (seq_busy),
      .done   (seq_done),
      .mcstall(mcstall)
   );

   // ID-stage dependency check: load-use with forwarding, any RAW without
   always_comb begin
      data_hazard = 1'b0;
      if (FWD_EN) begin
         data_hazard = load_e &&
                       (reg_hit(1'b1, rd_e, rs1_d) || reg_hit(1'b1, rd_e, rs2_d));
      end else begin
         data_hazard = reg_hit(reg_write_e, rd_e, rs1_d) || reg_hit(reg_write_e, rd_e, rs2_d) ||
                       reg_hit(reg_write_m, rd_m, rs1_d) || reg_hit(reg_write_m, rd_m, rs2_d) ||
                       reg_hit(reg_write_w, rd_w, rs1_d) || reg_hit(reg_write_w, rd_w, rs2_d);
      end
   end

   // Stall/flush priority; all outputs are held low while reset is asserted
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      flush_w = 1'b0;
      if (reset) begin
         if (mstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
         end else if (mcstall) begin
            // EX is held, so a redirect in EX waits until the op retires
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
         end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end else if (data_hazard) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // Forwarding mux selects and gated sequencer status
   always_comb begin
      forward_ae = FWD_RF;
      forward_be = FWD_RF;
      if (reset && FWD_EN) begin
         forward_ae = fwd_sel(rs1_e);
         forward_be = fwd_sel(rs2_e);
      end
      mc_busy = reset && seq_busy;
      mc_done = reset && seq_done;
   end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (forwarding/latency 4 and
// no-forwarding/latency 2) share stimulus and are compared every cycle with
// a cycle-age model, plus hand-computed literal expectations.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned AW    = 5;
   localparam int          LAT_A = 4;
   localparam int          LAT_B = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic          reg_write_e, reg_write_m, reg_write_w, load_e, pc_src_e;
   logic          mc_start_e, dmem_req_m, dmem_ready_m;

   logic       stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w;
   logic [1:0] forward_ae, forward_be;
   logic       mc_busy, mc_done;

   logic       b_stall_f, b_stall_d, b_stall_e, b_stall_m;
   logic       b_flush_d, b_flush_e, b_flush_m, b_flush_w;
   logic [1:0] b_forward_ae, b_forward_be;
   logic       b_mc_busy, b_mc_done;

   logic [13:0] out_a, out_b;

   int n_pass  = 0;
   int n_total = 0;
   // Model state: which EX cycle (1..LAT) of an op was reached; 0 = none
   int age_a   = 0;
   int age_b   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .REG_AW(AW), .MC_LATENCY(LAT_A), .FWD_EN(1'b1)
   ) u_dut (
      .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_e(reg_write_e),
      .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .load_e(load_e),
      .pc_src_e(pc_src_e), .mc_start_e(mc_start_e), .dmem_req_m(dmem_req_m),
      .dmem_ready_m(dmem_ready_m), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
      .stall_m(stall_m), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
      .flush_w(flush_w), .forward_ae(forward_ae), .forward_be(forward_be),
      .mc_busy(mc_busy), .mc_done(mc_done)
   );

   pipeline_hazard_ctrl #(
      .REG_AW(AW), .MC_LATENCY(LAT_B), .FWD_EN(1'b0)
   ) u_dut_nf (
      .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .reg_write_e(reg_write_e),
      .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .load_e(load_e),
      .pc_src_e(pc_src_e), .mc_start_e(mc_start_e), .dmem_req_m(dmem_req_m),
      .dmem_ready_m(dmem_ready_m), .stall_f(b_stall_f), .stall_d(b_stall_d),
      .stall_e(b_stall_e), .stall_m(b_stall_m), .flush_d(b_flush_d), .flush_e(b_flush_e),
      .flush_m(b_flush_m), .flush_w(b_flush_w), .forward_ae(b_forward_ae),
      .forward_be(b_forward_be), .mc_busy(b_mc_busy), .mc_done(b_mc_done)
   );

   assign out_a = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                   forward_ae, forward_be, mc_busy, mc_done};
   assign out_b = {b_stall_f, b_stall_d, b_stall_e, b_stall_m, b_flush_d, b_flush_e,
                   b_flush_m, b_flush_w, b_forward_ae, b_forward_be, b_mc_busy, b_mc_done};

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   function automatic int eff_age(input int age);
      return (age == 0 && mc_start_e) ? 1 : age;
   endfunction

   function automatic int next_age(input int age, input int lat);
      int a = eff_age(age);
      return (a == 0 || a == lat) ? 0 : a + 1;
   endfunction

   function automatic bit reads(input logic [AW-1:0] rd);
      return rd != '0 && (rd == rs1_d || rd == rs2_d);
   endfunction

   function automatic logic [1:0] fwd_of(input logic [AW-1:0] rs);
      if (reg_write_m && rd_m != '0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != '0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [13:0] expect_out(input bit fwd_en, input int lat, input int age);
      bit ms, mc, hold, redir, haz;
      int a;
      if (reset !== 1'b1) return '0;
      a     = eff_age(age);
      ms    = dmem_req_m && !dmem_ready_m;
      mc    = !ms && a >= 1 && a < lat;
      hold  = ms || mc;
      redir = !hold && pc_src_e;
      if (fwd_en) haz = load_e && reads(rd_e);
      else haz = (reg_write_e && reads(rd_e)) || (reg_write_m && reads(rd_m)) ||
                 (reg_write_w && reads(rd_w));
      haz = haz && !hold && !redir;
      return {hold || haz, hold || haz, hold, ms, redir, redir || haz, mc, ms,
              fwd_en ? fwd_of(rs1_e) : 2'b00, fwd_en ? fwd_of(rs2_e) : 2'b00,
              age != 0, age == lat};
   endfunction

   // Model state advances on the DUT's edges; frozen while memory waits
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         age_a <= 0;
         age_b <= 0;
      end else if (!(dmem_req_m && !dmem_ready_m)) begin
         age_a <= next_age(age_a, LAT_A);
         age_b <= next_age(age_b, LAT_B);
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("model_fwd_lat4", {2'b00, out_a}, {2'b00, expect_out(1'b1, LAT_A, age_a)});
      chk("model_nofwd_lat2", {2'b00, out_b}, {2'b00, expect_out(1'b0, LAT_B, age_b)});
   end

   // ---------------- directed stimulus ----------------
   task automatic clear_inputs();
      {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
      {reg_write_e, reg_write_m, reg_write_w, load_e, pc_src_e} = '0;
      {mc_start_e, dmem_req_m} = '0;
      dmem_ready_m = 1'b1;
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   initial begin
      clear_inputs();
      reset = 1'b0;
      // Reset forces outputs low even with active inputs
      mc_start_e = 1'b1; dmem_req_m = 1'b1; dmem_ready_m = 1'b0; pc_src_e = 1'b1;
      rd_m = 5'd3; rs1_e = 5'd3; reg_write_m = 1'b1;
      sample();
      chk("rst_stall_f", stall_f, 1'b0);
      chk("rst_flush_w", flush_w, 1'b0);
      chk("rst_fwd_a", forward_ae, 2'b00);
      chk("rst_busy", mc_busy, 1'b0);
      next(); clear_inputs(); reset = 1'b1;
      sample();
      chk("idle_all", out_a, 14'h0);

      // Forwarding priority: MEM over WB, then WB, then x0
      next(); rd_m = 5'd5; reg_write_m = 1'b1; rs1_e = 5'd5; rd_w = 5'd5; reg_write_w = 1'b1;
      rs2_e = 5'd5;
      sample(); chk("fwd_mem_a", forward_ae, 2'b10); chk("fwd_mem_b", forward_be, 2'b10);
      chk("nofwd_a", b_forward_ae, 2'b00);
      next(); reg_write_m = 1'b0;
      sample(); chk("fwd_wb_a", forward_ae, 2'b01);
      next(); rs1_e = 5'd0;
      sample(); chk("fwd_rf_a", forward_ae, 2'b00); chk("fwd_wb_b", forward_be, 2'b01);
      next(); clear_inputs(); rd_m = 5'd0; rs1_e = 5'd0; reg_write_m = 1'b1;
      sample(); chk("fwd_x0", forward_ae, 2'b00);

      // Load-use stall, then rd_e = x0 gives nothing
      next(); clear_inputs(); load_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
      sample();
      chk("lu_stall_f", stall_f, 1'b1); chk("lu_stall_d", stall_d, 1'b1);
      chk("lu_flush_e", flush_e, 1'b1); chk("lu_stall_e", stall_e, 1'b0);
      next(); rd_e = 5'd0; rs2_d = 5'd0;
      sample(); chk("lu_x0", out_a, 14'h0);

      // Redirect beats load-use
      next(); rd_e = 5'd7; rs2_d = 5'd7; pc_src_e = 1'b1;
      sample();
      chk("redir_flush_d", flush_d, 1'b1); chk("redir_flush_e", flush_e, 1'b1);
      chk("redir_stall_f", stall_f, 1'b0);

      // RAW stall only without forwarding
      next(); clear_inputs(); reg_write_m = 1'b1; rd_m = 5'd9; rs1_d = 5'd9;
      sample(); chk("raw_nf_stall", b_stall_f, 1'b1); chk("raw_fwd_none", stall_f, 1'b0);

      // Multi-cycle op with a pending redirect: no flush until done
      next(); clear_inputs(); mc_start_e = 1'b1; pc_src_e = 1'b1;
      for (int c = 1; c <= LAT_A; c++) begin
         sample();
         chk($sformatf("mc_stall_e_c%0d", c), stall_e, c < LAT_A);
         chk($sformatf("mc_flush_m_c%0d", c), flush_m, c < LAT_A);
         chk($sformatf("mc_done_c%0d", c), mc_done, c == LAT_A);
         chk($sformatf("mc_flush_d_c%0d", c), flush_d, c == LAT_A);
         next();
      end
      clear_inputs();

      // One mstall inside the op stretches it to five cycles
      mc_start_e = 1'b1;
      for (int c = 1; c <= LAT_A + 1; c++) begin
         dmem_req_m = (c == 2); dmem_ready_m = 1'b0;
         sample();
         if (c == 2) begin
            chk("ms_stall_m", stall_m, 1'b1); chk("ms_flush_w", flush_w, 1'b1);
            chk("ms_flush_m", flush_m, 1'b0); chk("ms_busy", mc_busy, 1'b1);
         end
         chk($sformatf("mcms_done_c%0d", c), mc_done, c == LAT_A + 1);
         next();
      end
      clear_inputs();

      // mstall during the done cycle keeps done high
      mc_start_e = 1'b1;
      for (int c = 1; c <= LAT_A + 1; c++) begin
         dmem_req_m = (c == LAT_A); dmem_ready_m = 1'b0;
         sample();
         chk($sformatf("msd_done_c%0d", c), mc_done, c >= LAT_A);
         chk($sformatf("msd_stall_e_c%0d", c), stall_e, c <= LAT_A);
         next();
      end
      clear_inputs();

      // Pure memory wait for three cycles
      dmem_req_m = 1'b1; dmem_ready_m = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         sample();
         chk($sformatf("mw_vec_c%0d", c), out_a[13:6], 8'b1111_0001);
         next();
      end
      dmem_ready_m = 1'b1;
      sample(); chk("mw_release", out_a, 14'h0);

      // Back-to-back ops: done in cycles 4 and 8
      next(); mc_start_e = 1'b1;
      for (int c = 1; c <= 2 * LAT_A; c++) begin
         sample();
         chk($sformatf("b2b_done_c%0d", c), mc_done, c == LAT_A || c == 2 * LAT_A);
         next();
      end
      clear_inputs();

      // Reset in BUSY cycle 2, release with start held: fresh count
      mc_start_e = 1'b1;
      sample(); next();
      reset = 1'b0;
      sample(); chk("rmid_out", out_a, 14'h0); chk("rmid_busy", mc_busy, 1'b0);
      next(); reset = 1'b1;
      for (int c = 1; c <= LAT_A; c++) begin
         sample();
         chk($sformatf("rrel_stall_e_c%0d", c), stall_e, c < LAT_A);
         chk($sformatf("rrel_done_c%0d", c), mc_done, c == LAT_A);
         next();
      end
      clear_inputs();
      sample();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
